// File: rtl/ip_arp_lut_pkg.sv
// Shared types and widths for the next-hop IP -> MAC resolution stage.
package ip_arp_lut_pkg;

  localparam int IP_WIDTH  = 32;
  localparam int MAC_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    HOLD  = 2'd2
  } arp_state_e;

endpackage

// File: rtl/ip_arp_lut_if.sv
// Lookup handshake plus table register port between the LPM stage, the
// header-rewrite stage, the register block and the ARP resolver.
interface ip_arp_lut_if import ip_arp_lut_pkg::*; #(
  parameter int NUM_QUEUES         = 8,
  parameter int ARP_LUT_DEPTH_BITS = 5
);

  logic [IP_WIDTH-1:0]           next_hop_ip;
  logic [NUM_QUEUES-1:0]         lpm_output_port;
  logic                          lpm_vld;
  logic                          lpm_hit;
  logic                          arp_done;
  logic                          arp_vld;
  logic                          arp_rd_en;
  logic [MAC_WIDTH-1:0]          arp_mac;
  logic [NUM_QUEUES-1:0]         arp_output_port;
  logic                          arp_lookup_hit;
  logic [ARP_LUT_DEPTH_BITS-1:0] arp_rd_addr;
  logic                          arp_rd_req;
  logic [IP_WIDTH-1:0]           arp_rd_ip;
  logic [MAC_WIDTH-1:0]          arp_rd_mac;
  logic                          arp_rd_ack;
  logic [ARP_LUT_DEPTH_BITS-1:0] arp_wr_addr;
  logic                          arp_wr_req;
  logic [IP_WIDTH-1:0]           arp_wr_ip;
  logic [MAC_WIDTH-1:0]          arp_wr_mac;
  logic                          arp_wr_ack;

  modport master (
    output next_hop_ip, lpm_output_port, lpm_vld, lpm_hit, arp_rd_en,
           arp_rd_addr, arp_rd_req, arp_wr_addr, arp_wr_req, arp_wr_ip, arp_wr_mac,
    input  arp_done, arp_vld, arp_mac, arp_output_port, arp_lookup_hit,
           arp_rd_ip, arp_rd_mac, arp_rd_ack, arp_wr_ack
  );

  modport slave (
    input  next_hop_ip, lpm_output_port, lpm_vld, lpm_hit, arp_rd_en,
           arp_rd_addr, arp_rd_req, arp_wr_addr, arp_wr_req, arp_wr_ip, arp_wr_mac,
    output arp_done, arp_vld, arp_mac, arp_output_port, arp_lookup_hit,
           arp_rd_ip, arp_rd_mac, arp_rd_ack, arp_wr_ack
  );

endinterface

// File: rtl/arp_prio_match.sv
// Single-cycle associative compare of a key against every valid ARP entry;
// the lowest matching index wins.
module arp_prio_match import ip_arp_lut_pkg::*; #(
  parameter int ARP_LUT_DEPTH      = 32,
  parameter int ARP_LUT_DEPTH_BITS = 5
) (
  input  logic [ARP_LUT_DEPTH-1:0][IP_WIDTH-1:0] ip_vec,
  input  logic [ARP_LUT_DEPTH-1:0]               valid,
  input  logic [IP_WIDTH-1:0]                    key,
  output logic                                   match,
  output logic [ARP_LUT_DEPTH_BITS-1:0]          match_idx
);

  // Scanning from the top down lets the lowest hit overwrite any higher one.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = ARP_LUT_DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (ip_vec[i] == key)) begin
        match     = 1'b1;
        match_idx = ARP_LUT_DEPTH_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/ip_arp_lut.sv
// Next-hop IP -> MAC resolver: flop-based ARP table, IDLE/MATCH/HOLD lookup
// FSM and a register read/write port into the table.
module ip_arp_lut import ip_arp_lut_pkg::*; #(
  parameter int NUM_QUEUES         = 8,
  parameter int ARP_LUT_DEPTH      = 32,
  parameter int ARP_LUT_DEPTH_BITS = $clog2(ARP_LUT_DEPTH)
) (
  input logic         clk,
  input logic         resetn,
  ip_arp_lut_if.slave bus
);

  arp_state_e                               state_q, state_d;
  logic [IP_WIDTH-1:0]                      key_ip_q, key_ip_d;
  logic [NUM_QUEUES-1:0]                    key_port_q, key_port_d;
  logic                                     key_hit_q, key_hit_d;
  logic                                     vld_q, vld_d, done_q, done_d, hit_q, hit_d;
  logic [MAC_WIDTH-1:0]                     mac_q, mac_d;
  logic [NUM_QUEUES-1:0]                    port_q, port_d;
  logic [ARP_LUT_DEPTH-1:0][IP_WIDTH-1:0]   tbl_ip_q, tbl_ip_d;
  logic [ARP_LUT_DEPTH-1:0][MAC_WIDTH-1:0]  tbl_mac_q, tbl_mac_d;
  logic [ARP_LUT_DEPTH-1:0]                 tbl_valid;
  logic                                     match;
  logic [ARP_LUT_DEPTH_BITS-1:0]            match_idx;
  logic [IP_WIDTH-1:0]                      rd_ip_q, rd_ip_d;
  logic [MAC_WIDTH-1:0]                     rd_mac_q, rd_mac_d;
  logic                                     rd_ack_q, rd_ack_d;
  logic                                     wr_pend_q, wr_pend_d, wr_done_q, wr_done_d;
  logic                                     wr_ack_q, wr_ack_d;
  logic [ARP_LUT_DEPTH_BITS-1:0]            wr_addr_q, wr_addr_d;
  logic [IP_WIDTH-1:0]                      wr_ip_q, wr_ip_d;
  logic [MAC_WIDTH-1:0]                     wr_mac_q, wr_mac_d;
  logic                                     wr_accept, wr_commit;
  logic [ARP_LUT_DEPTH_BITS-1:0]            commit_addr;
  logic [IP_WIDTH-1:0]                      commit_ip;
  logic [MAC_WIDTH-1:0]                     commit_mac;

  always_comb begin
    tbl_valid = '0;
    for (int i = 0; i < ARP_LUT_DEPTH; i++) begin
      tbl_valid[i] = |tbl_ip_q[i];
    end
  end

  arp_prio_match #(
    .ARP_LUT_DEPTH      (ARP_LUT_DEPTH),
    .ARP_LUT_DEPTH_BITS (ARP_LUT_DEPTH_BITS)
  ) u_prio_match (
    .ip_vec    (tbl_ip_q),
    .valid     (tbl_valid),
    .key       (key_ip_q),
    .match     (match),
    .match_idx (match_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.lpm_vld) state_d = MATCH;
      MATCH:   state_d = HOLD;
      HOLD:    if (bus.arp_rd_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_ip_d   = key_ip_q;
    key_port_d = key_port_q;
    key_hit_d  = key_hit_q;
    vld_d      = vld_q;
    done_d     = 1'b0;
    mac_d      = mac_q;
    port_d     = port_q;
    hit_d      = hit_q;
    unique case (state_q)
      IDLE: begin
        if (bus.lpm_vld) begin
          key_ip_d   = bus.next_hop_ip;
          key_port_d = bus.lpm_output_port;
          key_hit_d  = bus.lpm_hit;
        end
      end
      MATCH: begin
        vld_d  = 1'b1;
        port_d = key_port_q;
        hit_d  = key_hit_q & match;
        mac_d  = (key_hit_q && match) ? tbl_mac_q[match_idx] : '0;
      end
      HOLD: begin
        if (bus.arp_rd_en) begin
          vld_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A write sampled during MATCH is parked for one cycle so it commits in HOLD.
  always_comb begin
    wr_accept   = bus.arp_wr_req & ~(wr_pend_q | wr_done_q | wr_ack_q);
    wr_pend_d   = wr_accept & (state_q == MATCH);
    wr_commit   = (wr_accept & (state_q != MATCH)) | wr_pend_q;
    wr_addr_d   = wr_pend_d ? bus.arp_wr_addr : wr_addr_q;
    wr_ip_d     = wr_pend_d ? bus.arp_wr_ip   : wr_ip_q;
    wr_mac_d    = wr_pend_d ? bus.arp_wr_mac  : wr_mac_q;
    commit_addr = wr_pend_q ? wr_addr_q : bus.arp_wr_addr;
    commit_ip   = wr_pend_q ? wr_ip_q   : bus.arp_wr_ip;
    commit_mac  = wr_pend_q ? wr_mac_q  : bus.arp_wr_mac;
    tbl_ip_d    = tbl_ip_q;
    tbl_mac_d   = tbl_mac_q;
    if (wr_commit) begin
      tbl_ip_d[commit_addr]  = commit_ip;
      tbl_mac_d[commit_addr] = commit_mac;
    end
    wr_done_d = wr_commit;
    wr_ack_d  = wr_done_q;
  end

  always_comb begin
    rd_ack_d = bus.arp_rd_req & ~rd_ack_q;
    rd_ip_d  = rd_ip_q;
    rd_mac_d = rd_mac_q;
    if (rd_ack_d) begin
      rd_ip_d  = tbl_ip_q[bus.arp_rd_addr];
      rd_mac_d = tbl_mac_q[bus.arp_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_ip_q   <= '0;
      key_port_q <= '0;
      key_hit_q  <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      mac_q      <= '0;
      port_q     <= '0;
      hit_q      <= 1'b0;
      tbl_ip_q   <= '0;
      tbl_mac_q  <= '0;
      rd_ip_q    <= '0;
      rd_mac_q   <= '0;
      rd_ack_q   <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_ip_q    <= '0;
      wr_mac_q   <= '0;
    end else begin
      key_ip_q   <= key_ip_d;
      key_port_q <= key_port_d;
      key_hit_q  <= key_hit_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      mac_q      <= mac_d;
      port_q     <= port_d;
      hit_q      <= hit_d;
      tbl_ip_q   <= tbl_ip_d;
      tbl_mac_q  <= tbl_mac_d;
      rd_ip_q    <= rd_ip_d;
      rd_mac_q   <= rd_mac_d;
      rd_ack_q   <= rd_ack_d;
      wr_pend_q  <= wr_pend_d;
      wr_done_q  <= wr_done_d;
      wr_ack_q   <= wr_ack_d;
      wr_addr_q  <= wr_addr_d;
      wr_ip_q    <= wr_ip_d;
      wr_mac_q   <= wr_mac_d;
    end
  end

  assign bus.arp_vld         = vld_q;
  assign bus.arp_done        = done_q;
  assign bus.arp_mac         = mac_q;
  assign bus.arp_output_port = port_q;
  assign bus.arp_lookup_hit  = hit_q;
  assign bus.arp_rd_ip       = rd_ip_q;
  assign bus.arp_rd_mac      = rd_mac_q;
  assign bus.arp_rd_ack      = rd_ack_q;
  assign bus.arp_wr_ack      = wr_ack_q;

endmodule

// File: tb/tb_ip_arp_lut.sv
// Scoreboard bench for ip_arp_lut: stimulus tasks queue expected responses,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_ip_arp_lut;
  import ip_arp_lut_pkg::*;

  localparam int NQ    = 8;
  localparam int DEPTH = 32;
  localparam int DB    = 5;

  localparam logic [31:0] IP_A = 32'h0A00_0002;
  localparam logic [31:0] IP_B = 32'h0A00_0005;
  localparam logic [31:0] IP_C = 32'h0A00_0007;
  localparam logic [31:0] IP_U = 32'hC0A8_0101;
  localparam logic [47:0] MAC_A   = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_B5  = 48'hAAAA_AAAA_0005;
  localparam logic [47:0] MAC_B9  = 48'hBBBB_BBBB_0009;
  localparam logic [47:0] MAC_C   = 48'h0000_0000_0007;
  localparam logic [47:0] MAC_C2  = 48'h0000_0000_0077;
  localparam logic [47:0] MAC_DEL = 48'h0000_DEAD_0000;

  typedef struct {
    logic [47:0] mac;
    logic [7:0]  port;
    logic        hit;
    int          at;
  } lk_t;

  typedef struct {
    logic [31:0] ip;
    logic [47:0] mac;
    int          at;
  } rd_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  lk_t  lk_q[$];
  rd_t  rd_q[$];
  int   done_q[$];
  int   wr_q[$];
  lk_t  cur;
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ip_arp_lut_if #(.NUM_QUEUES(NQ), .ARP_LUT_DEPTH_BITS(DB)) bus ();

  ip_arp_lut #(
    .NUM_QUEUES         (NQ),
    .ARP_LUT_DEPTH      (DEPTH),
    .ARP_LUT_DEPTH_BITS (DB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=asserted required=idle", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"},  64'(bus.arp_vld), 64'd0);
    check({tag, "_done"}, 64'(bus.arp_done), 64'd0);
    check({tag, "_mac"},  64'(bus.arp_mac), 64'd0);
    check({tag, "_port"}, 64'(bus.arp_output_port), 64'd0);
    check({tag, "_hit"},  64'(bus.arp_lookup_hit), 64'd0);
    check({tag, "_rdip"}, 64'(bus.arp_rd_ip), 64'd0);
    check({tag, "_rdmac"},64'(bus.arp_rd_mac), 64'd0);
    check({tag, "_rdack"},64'(bus.arp_rd_ack), 64'd0);
    check({tag, "_wrack"},64'(bus.arp_wr_ack), 64'd0);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] ip,
                          input logic [47:0] mac, input int lat);
    wr_q.push_back(cyc + lat);
    bus.arp_wr_addr = addr;
    bus.arp_wr_ip   = ip;
    bus.arp_wr_mac  = mac;
    bus.arp_wr_req  = 1'b1;
    tick(1);
    bus.arp_wr_req  = 1'b0;
    tick(lat);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] ip, input logic [47:0] mac);
    rd_t e;
    e.ip  = ip;
    e.mac = mac;
    e.at  = cyc + 1;
    rd_q.push_back(e);
    bus.arp_rd_addr = addr;
    bus.arp_rd_req  = 1'b1;
    tick(1);
    bus.arp_rd_req  = 1'b0;
    tick(1);
  endtask

  task automatic do_lookup(input logic [31:0] ip, input logic [7:0] port, input logic hit,
                           input logic [47:0] exp_mac, input logic exp_hit);
    lk_t e;
    e.mac  = exp_mac;
    e.port = port;
    e.hit  = exp_hit;
    e.at   = cyc + 2;
    lk_q.push_back(e);
    bus.next_hop_ip     = ip;
    bus.lpm_output_port = port;
    bus.lpm_hit         = hit;
    bus.lpm_vld         = 1'b1;
    tick(1);
    bus.lpm_vld         = 1'b0;
  endtask

  task automatic consume();
    done_q.push_back(cyc + 1);
    bus.arp_rd_en = 1'b1;
    tick(1);
    bus.arp_rd_en = 1'b0;
  endtask

  // Monitor: every DUT response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.arp_vld && !prev_vld) begin
        if (lk_q.size() == 0) unexpected("lookup_vld");
        else begin
          lk_t e;
          e = lk_q.pop_front();
          cur <= e;
          check("lookup_cycle", 64'(cyc), 64'(e.at));
          check("lookup_mac",   64'(bus.arp_mac), 64'(e.mac));
          check("lookup_port",  64'(bus.arp_output_port), 64'(e.port));
          check("lookup_hit",   64'(bus.arp_lookup_hit), 64'(e.hit));
        end
      end else if (bus.arp_vld) begin
        check("hold_mac",  64'(bus.arp_mac), 64'(cur.mac));
        check("hold_port", 64'(bus.arp_output_port), 64'(cur.port));
        check("hold_hit",  64'(bus.arp_lookup_hit), 64'(cur.hit));
      end
      if (bus.arp_done) begin
        if (done_q.size() == 0) unexpected("arp_done");
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
      if (bus.arp_rd_ack) begin
        if (rd_q.size() == 0) unexpected("rd_ack");
        else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(r.at));
          check("rd_ip",    64'(bus.arp_rd_ip), 64'(r.ip));
          check("rd_mac",   64'(bus.arp_rd_mac), 64'(r.mac));
        end
      end
      if (bus.arp_wr_ack) begin
        if (wr_q.size() == 0) unexpected("wr_ack");
        else check("wr_ack_cycle", 64'(cyc), 64'(wr_q.pop_front()));
      end
    end
    prev_vld <= bus.arp_vld;
  end

  initial begin
    bus.next_hop_ip     = '0;
    bus.lpm_output_port = '0;
    bus.lpm_vld         = 1'b0;
    bus.lpm_hit         = 1'b0;
    bus.arp_rd_en       = 1'b0;
    bus.arp_rd_addr     = '0;
    bus.arp_rd_req      = 1'b0;
    bus.arp_wr_addr     = '0;
    bus.arp_wr_req      = 1'b0;
    bus.arp_wr_ip       = '0;
    bus.arp_wr_mac      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");
    resetn = 1'b1;
    tick(2);

    $display("[TB] basic resolve");
    do_write(5'd3, IP_A, MAC_A, 2);
    do_lookup(IP_A, 8'h04, 1'b1, MAC_A, 1'b1);
    tick(1);
    consume();
    tick(2);

    $display("[TB] lowest index wins");
    do_write(5'd5, IP_B, MAC_B5, 2);
    do_write(5'd9, IP_B, MAC_B9, 2);
    do_lookup(IP_B, 8'h10, 1'b1, MAC_B5, 1'b1);
    tick(1);
    consume();
    tick(1);
    do_read(5'd5, IP_B, MAC_B5);
    do_read(5'd9, IP_B, MAC_B9);

    $display("[TB] lpm miss and unknown ip");
    do_lookup(IP_A, 8'h21, 1'b0, 48'h0, 1'b0);
    tick(1);
    consume();
    tick(1);
    do_lookup(IP_U, 8'h02, 1'b1, 48'h0, 1'b0);
    tick(1);
    consume();
    tick(1);
    do_write(5'd3, 32'h0, MAC_DEL, 2);
    do_read(5'd3, 32'h0, MAC_DEL);
    do_lookup(IP_A, 8'h04, 1'b1, 48'h0, 1'b0);
    tick(1);
    consume();
    tick(1);

    $display("[TB] rd_en while idle produces no done");
    bus.arp_rd_en = 1'b1;
    tick(1);
    bus.arp_rd_en = 1'b0;
    tick(2);

    $display("[TB] long hold with stray lpm_vld");
    do_lookup(IP_B, 8'h80, 1'b1, MAC_B5, 1'b1);
    tick(4);
    bus.next_hop_ip     = IP_B;
    bus.lpm_output_port = 8'h01;
    bus.lpm_hit         = 1'b1;
    bus.lpm_vld         = 1'b1;
    tick(1);
    bus.lpm_vld         = 1'b0;
    tick(6);
    consume();
    tick(2);

    $display("[TB] write deferred during match");
    do_write(5'd7, IP_C, MAC_C, 2);
    do_lookup(IP_C, 8'h08, 1'b1, MAC_C, 1'b1);
    do_write(5'd7, IP_C, MAC_C2, 3);
    consume();
    tick(1);
    do_read(5'd7, IP_C, MAC_C2);

    $display("[TB] reset while holding");
    do_lookup(IP_C, 8'h40, 1'b1, MAC_C2, 1'b1);
    tick(2);
    resetn = 1'b0;
    #1;
    check_idle_outputs("hold_reset");
    tick(2);
    resetn = 1'b1;
    tick(1);
    do_read(5'd5, 32'h0, 48'h0);
    do_read(5'd7, 32'h0, 48'h0);
    do_read(5'd9, 32'h0, 48'h0);
    tick(3);

    check("leftover_lookups", 64'(lk_q.size()), 64'd0);
    check("leftover_dones",   64'(done_q.size()), 64'd0);
    check("leftover_reads",   64'(rd_q.size()), 64'd0);
    check("leftover_writes",  64'(wr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
